// File: rtl/project_pwm_peripheral_capture_pkg.sv
// Shared definitions for the PWM input-capture unit: FSM encoding, default
// sizes and the register-map offsets used by the peripheral register file.
package project_pwm_peripheral_capture_pkg;

  localparam int CAP_WIDTH_DEFAULT = 16;
  localparam int CAP_SYNC_DEFAULT  = 2;
  localparam int CAP_FILT_DEFAULT  = 3;

  // Byte offsets of the capture registers inside the peripheral map
  localparam logic [7:0] CAP_REG_CTRL   = 8'h00;
  localparam logic [7:0] CAP_REG_STATUS = 8'h04;
  localparam logic [7:0] CAP_REG_PERIOD = 8'h08;
  localparam logic [7:0] CAP_REG_HIGH   = 8'h0C;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ARM  = 2'd1,
    CAP_HIGH = 2'd2,
    CAP_LOW  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/project_pwm_input_conditioner.sv
// Front end of the capture unit: polarity select, synchronizer, optional
// glitch filter (macro PWM_CAPTURE_FILTER_EN) and edge detection.
module project_pwm_input_conditioner #(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_CYCLES = 3
`endif
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pwm,
  input  logic i_invert,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   level;
  logic                   level_prev_q;

  // Synchronize the polarity-corrected raw input
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm ^ i_invert};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int             FCW       = $clog2(FILT_CYCLES + 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_CYCLES - 1);

  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Follow the synchronized level only after FILT_CYCLES equal samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_s != filt_q) begin
      if (fcnt_q == FCNT_LAST) filt_d = sync_s;
      else                     fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Filter state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_s;
`endif

  // Previous level for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) level_prev_q <= 1'b0;
    else            level_prev_q <= level;
  end

  assign o_level = level;
  assign o_rise  = level & ~level_prev_q;
  assign o_fall  = ~level & level_prev_q;

endmodule

// File: rtl/project_pwm_peripheral_capture.sv
// PWM input-capture unit: measures period (rise to rise) and high time
// (rise to fall) of an external waveform in i_clk cycles.
// Optional glitch filter in the front end: define PWM_CAPTURE_FILTER_EN.
module project_pwm_peripheral_capture
  import project_pwm_peripheral_capture_pkg::*;
#(
  parameter int WIDTH       = CAP_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = CAP_SYNC_DEFAULT
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_CYCLES = CAP_FILT_DEFAULT
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_invert,
  input  logic             i_pwm,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic cond_rise, cond_fall;
  // The FSM is driven purely by edges; the level itself is not needed here.
  logic cond_level_unused;

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             capture;

  project_pwm_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
    , .FILT_CYCLES(FILT_CYCLES)
`endif
  ) u_cond (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_pwm    (i_pwm),
    .i_invert (i_invert),
    .o_level  (cond_level_unused),
    .o_rise   (cond_rise),
    .o_fall   (cond_fall)
  );

  // Next-state, counters, results and sticky flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    capture   = 1'b0;

    case (state_q)
      CAP_IDLE: begin
        if (i_en) state_d = CAP_ARM;
      end
      CAP_ARM: begin
        // First rise only starts timing; that period is never reported
        if (cond_rise) begin
          cnt_d   = CNT_ONE;
          state_d = CAP_HIGH;
        end
      end
      CAP_HIGH: begin
        if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = CAP_ARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cond_fall) begin
            hcnt_d  = cnt_q;
            state_d = CAP_LOW;
          end
        end
      end
      CAP_LOW: begin
        if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = CAP_ARM;
        end else if (cond_rise) begin
          capture  = 1'b1;
          period_d = cnt_q;
          high_d   = hcnt_q;
          cnt_d    = CNT_ONE;
          state_d  = CAP_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = CAP_IDLE;
    endcase

    // A capture wins over a simultaneous ack and leaves overrun untouched
    if (capture) begin
      if (valid_q && !i_ack) overrun_d = 1'b1;
      valid_d = 1'b1;
    end else if (i_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // Disable aborts any measurement; results are kept, flags cleared
    if (!i_en) begin
      state_d   = CAP_IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  // State and data registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= CAP_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_project_pwm_peripheral_capture.sv
// Testbench for the PWM input-capture unit. Reference model works on whole
// pulses (high length, low length): each rise after the first reports the
// previous pulse's lengths, LAT clocks after the raw rising edge.
module tb_project_pwm_peripheral_capture;

  localparam int W = 8;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic         clk;
  logic         i_reset_n, i_en, i_invert, i_pwm, i_ack;
  logic [W-1:0] o_period, o_high;
  logic         o_valid, o_overrun, o_timeout;

  int n_tests, n_fail;

  logic [W-1:0] m_period, m_high;
  bit           m_valid, m_overrun, m_timeout, m_prev_ok;
  int           m_prev_h, m_prev_l;
  int           hl[16];
  int           ll[16];

  project_pwm_peripheral_capture #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_reset_n(i_reset_n),
    .i_en     (i_en),
    .i_invert (i_invert),
    .i_pwm    (i_pwm),
    .i_ack    (i_ack),
    .o_period (o_period),
    .o_high   (o_high),
    .o_valid  (o_valid),
    .o_overrun(o_overrun),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Disable, settle the input at measured-low, then enable into ARM
  task automatic restart(input bit inv);
    i_en = 1'b0; i_ack = 1'b0; i_invert = inv; i_pwm = inv;
    repeat (LAT + 2) tick();
    m_valid = 0; m_overrun = 0; m_timeout = 0; m_prev_ok = 0;
    i_en = 1'b1;
    tick();
  endtask

  // Drive n measured pulses hl[p]/ll[p]; optional ack on pulse ack_at's capture
  task automatic drive(input int n, input bit inv, input int ack_at, input bit chk);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < hl[p] + ll[p]; c++) begin
        i_pwm = (c < hl[p]) ^ inv;
        i_ack = (p == ack_at && c == LAT - 1);
        tick();
        if (chk && c == LAT - 2) begin
          n_tests++;
          if (o_valid !== m_valid) begin
            n_fail++;
            $display("FAIL early_valid p=%0d got %b exp %b", p, o_valid, m_valid);
          end
        end
        if (chk && c == LAT - 1) begin
          if (m_prev_ok) begin
            if (m_valid && !i_ack) m_overrun = 1;
            m_valid  = 1;
            m_period = W'(m_prev_h + m_prev_l);
            m_high   = W'(m_prev_h);
          end else if (i_ack) begin
            m_valid = 0; m_overrun = 0;
          end
          n_tests++;
          if (o_period !== m_period) begin
            n_fail++;
            $display("FAIL period p=%0d got %0d exp %0d", p, o_period, m_period);
          end
          n_tests++;
          if (o_high !== m_high) begin
            n_fail++;
            $display("FAIL high p=%0d got %0d exp %0d", p, o_high, m_high);
          end
          n_tests++;
          if (o_valid !== m_valid) begin
            n_fail++;
            $display("FAIL valid p=%0d got %b exp %b", p, o_valid, m_valid);
          end
          n_tests++;
          if (o_overrun !== m_overrun) begin
            n_fail++;
            $display("FAIL overrun p=%0d got %b exp %b", p, o_overrun, m_overrun);
          end
          n_tests++;
          if (o_timeout !== m_timeout) begin
            n_fail++;
            $display("FAIL timeout p=%0d got %b exp %b", p, o_timeout, m_timeout);
          end
        end
        if (c == LAT - 1) begin
          m_prev_ok = 1; m_prev_h = hl[p]; m_prev_l = ll[p];
        end
      end
    end
    i_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_en = 1'b1; i_invert = 1'b0; i_pwm = 1'b1; i_ack = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (o_period !== '0) begin n_fail++; $display("FAIL rst_period got %0d exp 0", o_period); end
    n_tests++;
    if (o_high !== '0) begin n_fail++; $display("FAIL rst_high got %0d exp 0", o_high); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    n_tests++;
    if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", o_overrun); end
    n_tests++;
    if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b exp 0", o_timeout); end
    m_period = '0; m_high = '0;
    i_en = 1'b0; i_pwm = 1'b0;
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    restart(1'b0);
    for (int p = 0; p < 4; p++) begin hl[p] = 3; ll[p] = 5; end
    drive(4, 1'b0, -1, 1'b1);
  endtask

  task automatic test_invert();
    restart(1'b1);
    for (int p = 0; p < 4; p++) begin hl[p] = 5; ll[p] = 3; end
    drive(4, 1'b1, -1, 1'b1);
  endtask

  task automatic test_overrun_ack();
    restart(1'b0);
    for (int p = 0; p < 3; p++) begin
      hl[p] = $urandom_range(3, 9); ll[p] = $urandom_range(3, 9);
    end
    drive(3, 1'b0, -1, 1'b1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    m_valid = 0; m_overrun = 0;
    m_prev_l = m_prev_l + 1;
    n_tests++;
    if (o_valid !== m_valid) begin n_fail++; $display("FAIL ack_valid got %b exp %b", o_valid, m_valid); end
    n_tests++;
    if (o_overrun !== m_overrun) begin n_fail++; $display("FAIL ack_overrun got %b exp %b", o_overrun, m_overrun); end
    n_tests++;
    if (o_period !== m_period) begin n_fail++; $display("FAIL ack_hold got %0d exp %0d", o_period, m_period); end
    for (int p = 0; p < 2; p++) begin
      hl[p] = $urandom_range(3, 9); ll[p] = $urandom_range(3, 9);
    end
    drive(2, 1'b0, 1, 1'b1);
  endtask

  task automatic test_timeout();
    restart(1'b0);
    i_pwm = 1'b1;
    repeat (LAT + 254) tick();
    n_tests++;
    if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b exp 0", o_timeout); end
    tick();
    n_tests++;
    if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set got %b exp 1", o_timeout); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid got %b exp 0", o_valid); end
    m_timeout = 1; m_prev_ok = 0;
    i_pwm = 1'b0;
    repeat (LAT + 3) tick();
    for (int p = 0; p < 3; p++) begin hl[p] = 4; ll[p] = 6; end
    drive(3, 1'b0, -1, 1'b1);
  endtask

  task automatic test_en_drop();
    i_pwm = 1'b1;
    repeat (LAT) tick();
    if (m_valid) m_overrun = 1;
    m_valid = 1; m_period = W'(m_prev_h + m_prev_l); m_high = W'(m_prev_h);
    n_tests++;
    if (o_period !== m_period) begin n_fail++; $display("FAIL drop_pre_period got %0d exp %0d", o_period, m_period); end
    repeat (2) tick();
    i_en = 1'b0;
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid got %b exp 0", o_valid); end
    n_tests++;
    if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL drop_overrun got %b exp 0", o_overrun); end
    n_tests++;
    if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL drop_timeout got %b exp 0", o_timeout); end
    n_tests++;
    if (o_period !== m_period) begin n_fail++; $display("FAIL drop_period got %0d exp %0d", o_period, m_period); end
    n_tests++;
    if (o_high !== m_high) begin n_fail++; $display("FAIL drop_high got %0d exp %0d", o_high, m_high); end
    restart(1'b0);
    for (int p = 0; p < 3; p++) begin
      hl[p] = $urandom_range(3, 9); ll[p] = $urandom_range(3, 9);
    end
    drive(3, 1'b0, -1, 1'b1);
  endtask

  // A 2-cycle high glitch in the middle of an 8-cycle low phase
  task automatic test_glitch();
    restart(1'b0);
    hl[0] = 3; ll[0] = 8;
    hl[1] = 3; ll[1] = 8;
    hl[2] = 3; ll[2] = 3;
    hl[3] = 2; ll[3] = 3;
    drive(4, 1'b0, -1, 1'b0);
    i_pwm = 1'b1;
    repeat (LAT) tick();
`ifdef PWM_CAPTURE_FILTER_EN
    m_period = W'(11); m_high = W'(3);
`else
    m_period = W'(5); m_high = W'(2);
`endif
    n_tests++;
    if (o_period !== m_period) begin n_fail++; $display("FAIL glitch_period got %0d exp %0d", o_period, m_period); end
    n_tests++;
    if (o_high !== m_high) begin n_fail++; $display("FAIL glitch_high got %0d exp %0d", o_high, m_high); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      bit inv;
      int n, ack_at;
      inv = 1'($urandom_range(0, 1));
      n = $urandom_range(3, 6);
      ack_at = int'($urandom_range(0, n)) - 1;
      for (int p = 0; p < n; p++) begin
        hl[p] = $urandom_range(3, 9); ll[p] = $urandom_range(3, 9);
      end
      restart(inv);
      drive(n, inv, ack_at, 1'b1);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_valid = 0; m_overrun = 0; m_timeout = 0; m_prev_ok = 0;
    m_prev_h = 0; m_prev_l = 0;
    test_reset();
    test_basic();
    test_invert();
    test_overrun_ack();
    test_timeout();
    test_en_drop();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
